// File: rtl/reg_dump_scanner.sv
// Register-file dump engine: walks FIRST_REG..LAST_REG on the core debug read port,
// emits a 5-byte record per register, then a one-byte checksum trailer.
// Latency: first byte valid SETTLE_CYCLES edges after start; stream holds under backpressure.
module reg_dump_scanner #(
    parameter int FIRST_REG     = 1,
    parameter int LAST_REG      = 31,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  reg_addr,
    input  logic [31:0] reg_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SEND,
        S_TRAILER,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [4:0]    addr_nxt;
    logic [7:0]    csum, csum_nxt;
    logic [2:0]    byte_idx, byte_idx_nxt;
    logic [31:0]   data_q, data_nxt;
    logic          xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            reg_addr <= '0;
            csum     <= '0;
            byte_idx <= '0;
            data_q   <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            reg_addr <= addr_nxt;
            csum     <= csum_nxt;
            byte_idx <= byte_idx_nxt;
            data_q   <= data_nxt;
        end
    end

    // Outputs derive from registered state only, so out_valid never sees out_ready.
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        out_valid = (state == S_SEND) || (state == S_TRAILER);
        out_data  = 8'h00;
        if (state == S_SEND) begin
            case (byte_idx)
                3'd0:    out_data = {3'b000, reg_addr};
                3'd1:    out_data = data_q[31:24];
                3'd2:    out_data = data_q[23:16];
                3'd3:    out_data = data_q[15:8];
                3'd4:    out_data = data_q[7:0];
                default: out_data = 8'h00;
            endcase
        end else if (state == S_TRAILER) begin
            out_data = csum;
        end
    end

    assign xfer = out_valid && out_ready;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        addr_nxt     = reg_addr;
        csum_nxt     = csum;
        byte_idx_nxt = byte_idx;
        data_nxt     = data_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    addr_nxt  = 5'(FIRST_REG);
                    cnt_nxt   = CW'(SETTLE_CYCLES);
                    csum_nxt  = 8'h00;
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt == CW'(1)) begin
                    data_nxt     = reg_data;
                    byte_idx_nxt = 3'd0;
                    state_nxt    = S_SEND;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_SEND: begin
                if (xfer) begin
                    csum_nxt     = csum + out_data;
                    byte_idx_nxt = byte_idx + 3'd1;
                    if (byte_idx == 3'd4) begin
                        // Terminate at LAST_REG rather than incrementing, so 31 never wraps.
                        if (reg_addr == 5'(LAST_REG)) begin
                            state_nxt = S_TRAILER;
                        end else begin
                            addr_nxt  = reg_addr + 5'd1;
                            cnt_nxt   = CW'(SETTLE_CYCLES);
                            state_nxt = S_SETTLE;
                        end
                    end
                end
            end
            S_TRAILER: begin
                if (xfer) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                addr_nxt  = 5'd0;
                state_nxt = S_IDLE;
            end
            default: begin
                addr_nxt  = 5'd0;
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Bench for reg_dump_scanner: three parameterisations driven by directed dumps,
// byte stream checked by per-instance scoreboard monitors.
module tb_reg_dump_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_s     [3];
    logic        out_ready_s [3];
    logic        busy_s      [3];
    logic        done_s      [3];
    logic        out_valid_s [3];
    logic [4:0]  reg_addr_s  [3];
    logic [7:0]  out_data_s  [3];
    logic [31:0] reg_data_s  [3];
    logic [31:0] ovr_c;
    logic        bp;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt [3];
    logic [7:0] exp_q [3][$];

    localparam int SET [3] = '{1, 1, 3};

    // Core register-file models: x_i = i * 0x01010101 unless overridden.
    assign reg_data_s[0] = {4{3'b000, reg_addr_s[0]}};
    assign reg_data_s[1] = (reg_addr_s[1] == 5'd1) ? 32'h1234_5678 : 32'h0;
    assign reg_data_s[2] = (reg_addr_s[2] == 5'd1) ? ovr_c : {4{3'b000, reg_addr_s[2]}};

    reg_dump_scanner u_full (
        .clk(clk), .rst(rst), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .reg_addr(reg_addr_s[0]), .reg_data(reg_data_s[0]), .out_valid(out_valid_s[0]),
        .out_ready(out_ready_s[0]), .out_data(out_data_s[0]));

    reg_dump_scanner #(.FIRST_REG(1), .LAST_REG(1), .SETTLE_CYCLES(1)) u_one (
        .clk(clk), .rst(rst), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .reg_addr(reg_addr_s[1]), .reg_data(reg_data_s[1]), .out_valid(out_valid_s[1]),
        .out_ready(out_ready_s[1]), .out_data(out_data_s[1]));

    reg_dump_scanner #(.FIRST_REG(1), .LAST_REG(2), .SETTLE_CYCLES(3)) u_slow (
        .clk(clk), .rst(rst), .start(start_s[2]), .busy(busy_s[2]), .done(done_s[2]),
        .reg_addr(reg_addr_s[2]), .reg_data(reg_data_s[2]), .out_valid(out_valid_s[2]),
        .out_ready(out_ready_s[2]), .out_data(out_data_s[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_mon
        logic       stall_q;
        logic       valid_q;
        logic [7:0] dat_q;
        logic [4:0] addr_q;
        logic [4:0] last_addr;
        int         hold;
        initial begin
            stall_q = 1'b0; valid_q = 1'b0; dat_q = '0; addr_q = '0;
            last_addr = '0; hold = 0; done_cnt[g] = 0;
        end
        always @(negedge clk) begin
            if (reg_addr_s[g] == last_addr) hold++;
            else hold = 0;
            last_addr = reg_addr_s[g];
            if (rst) begin
                stall_q = 1'b0;
                valid_q = 1'b0;
            end else begin
                if (stall_q)
                    check($sformatf("stall_hold%0d", g), {out_valid_s[g], out_data_s[g], reg_addr_s[g]},
                          {1'b1, dat_q, addr_q});
                if (out_valid_s[g] && !valid_q && busy_s[g] && reg_addr_s[g] != 5'd0)
                    check($sformatf("addr_stable%0d", g), 32'(hold >= SET[g]), 32'd1);
                if (out_valid_s[g] && out_ready_s[g]) begin
                    if (exp_q[g].size() == 0) begin
                        check($sformatf("unexpected_byte%0d", g), {24'h0, out_data_s[g]}, 32'h100);
                    end else begin
                        check($sformatf("byte%0d", g), {24'h0, out_data_s[g]}, {24'h0, exp_q[g].pop_front()});
                    end
                end
                if (done_s[g]) done_cnt[g]++;
                stall_q = out_valid_s[g] && !out_ready_s[g];
                valid_q = out_valid_s[g];
                dat_q   = out_data_s[g];
                addr_q  = reg_addr_s[g];
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (bp) out_ready_s[0] = ($urandom_range(0, 99) < 30);
        end
    end

    task automatic push_rec(input int w, input logic [4:0] a, input logic [31:0] d);
        exp_q[w].push_back({3'b000, a});
        exp_q[w].push_back(d[31:24]);
        exp_q[w].push_back(d[23:16]);
        exp_q[w].push_back(d[15:8]);
        exp_q[w].push_back(d[7:0]);
    endtask

    task automatic push_full();
        for (int i = 1; i <= 31; i++) push_rec(0, 5'(i), {4{8'(i)}});
        exp_q[0].push_back(8'hB0);
    endtask

    // Starts a dump on instance w; edge k=0 is the edge that samples start.
    task automatic run_dump(input int w, input int budget, input int exp_edges, input int p1, input int p2);
        int seen;
        int dc0;
        seen = -1;
        dc0  = done_cnt[w];
        @(posedge clk); #1;
        start_s[w] = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            start_s[w] = (k == p1) || (k == p2);
            if (k == 0) begin
                check("busy_after_start", {31'h0, busy_s[w]}, 32'd1);
                check("addr_after_start", {27'h0, reg_addr_s[w]}, 32'd1);
            end
            if (w == 2) begin
                if (k == 1) ovr_c = 32'hCAFE_F00D;
                if (k == 2) ovr_c = 32'hA1B2_C3D4;
                if (k == 3) ovr_c = 32'h0BAD_F00D;
            end
            if (done_s[w]) begin
                seen = k;
                break;
            end
        end
        start_s[w] = 1'b0;
        if (seen < 0) begin
            check("done_timeout", 32'hFFFF_FFFF, 32'(budget));
        end else begin
            if (exp_edges >= 0) check("done_edge", 32'(seen), 32'(exp_edges));
            check("valid_at_done", {31'h0, out_valid_s[w]}, 32'd0);
            @(posedge clk); #1;
            check("done_one_cycle", {31'h0, done_s[w]}, 32'd0);
            check("busy_after_done", {31'h0, busy_s[w]}, 32'd0);
            check("addr_after_done", {27'h0, reg_addr_s[w]}, 32'd0);
        end
        repeat (10) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q[w].size()), 32'd0);
        check("single_done", 32'(done_cnt[w] - dc0), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        bp  = 1'b0;
        ovr_c = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            start_s[i] = 1'b0;
            out_ready_s[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", {31'h0, busy_s[0]}, 32'd0);
        check("rst_done", {31'h0, done_s[0]}, 32'd0);
        check("rst_valid", {31'h0, out_valid_s[0]}, 32'd0);
        check("rst_data", {24'h0, out_data_s[0]}, 32'd0);
        check("rst_addr", {27'h0, reg_addr_s[0]}, 32'd0);

        // Single register: 01 12 34 56 78, trailer 0x15.
        exp_q[1].push_back(8'h01); exp_q[1].push_back(8'h12); exp_q[1].push_back(8'h34);
        exp_q[1].push_back(8'h56); exp_q[1].push_back(8'h78); exp_q[1].push_back(8'h15);
        run_dump(1, 50, 7, -1, -1);

        // Full dump with stray start pulses at cycles 3 and 20.
        push_full();
        run_dump(0, 400, 187, 3, 20);

        // Same dump under random backpressure.
        push_full();
        bp = 1'b1;
        run_dump(0, 4000, -1, -1, -1);
        bp = 1'b0;
        out_ready_s[0] = 1'b1;

        // Reset while byte 2 of x4 is presented (edge 21 after start).
        push_full();
        @(posedge clk); #1;
        start_s[0] = 1'b1;
        for (int k = 0; k <= 21; k++) begin
            @(posedge clk); #1;
            start_s[0] = 1'b0;
        end
        check("pre_rst_valid", {31'h0, out_valid_s[0]}, 32'd1);
        check("pre_rst_addr", {27'h0, reg_addr_s[0]}, 32'd4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_valid", {31'h0, out_valid_s[0]}, 32'd0);
        check("abort_busy", {31'h0, busy_s[0]}, 32'd0);
        check("abort_addr", {27'h0, reg_addr_s[0]}, 32'd0);
        check("abort_done", {31'h0, done_s[0]}, 32'd0);
        exp_q[0].delete();
        push_full();
        run_dump(0, 400, 187, -1, -1);

        // Slow settle: x1 changes during the window; final-cycle value 0xA1B2C3D4 is taken.
        push_rec(2, 5'd1, 32'hA1B2_C3D4);
        push_rec(2, 5'd2, 32'h0202_0202);
        exp_q[2].push_back(8'hF5);
        run_dump(2, 100, 17, -1, -1);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_dump_scanner.md
# reg_dump_scanner

Hardware register-file dump engine that sits directly downstream of the tinyrv1 core's debug register read port (`debug_reg_addr` / `debug_reg_data`). On a start pulse it walks a range of architectural registers. For each register it emits a 5-byte record on a valid/ready byte stream, and it closes the dump with a one-byte checksum trailer. On the FPGA it takes the place of the bench-side register verification and feeds a UART transmitter or similar byte sink.

## Interface
- FIRST_REG, default 1: first register index scanned (0..31).
- LAST_REG, default 31: last register index scanned; must be ≥ FIRST_REG.
- SETTLE_CYCLES, default 1: number of cycles `reg_addr` is held before `reg_data` is sampled; must be ≥ 1.

- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  pulse that begins a dump; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE is exited.
- done  out  1  one-cycle pulse when the dump has completed.
- reg_addr  out  5  drives the core's `debug_reg_addr`.
- reg_data  in  32  from the core's `debug_reg_data`; treated as combinational from `reg_addr`.
- out_valid  out  1  byte available on out_data.
- out_ready  in  1  sink accepts the byte; a transfer occurs when out_valid and out_ready are both high at a rising edge.
- out_data  out  8  stream byte.

## Operation
- States: IDLE, SETTLE, SEND, TRAILER, DONE.
- IDLE:
  - reg_addr=0, busy=0, out_valid=0.
  - start=1 loads reg_addr=FIRST_REG, the settle counter=SETTLE_CYCLES and the checksum=0, then moves to SETTLE.
- SETTLE:
  - The counter decrements each cycle.
  - On the last settle cycle (counter==1), reg_data is latched into a 32-bit data register, byte_idx=0, and the state moves to SEND.
- SEND:
  - out_valid=1.
  - out_data by byte_idx: 0 → {3'b000, reg_addr}; 1 → data[31:24]; 2 → data[23:16]; 3 → data[15:8]; 4 → data[7:0].
  - On each transfer: checksum += out_data (mod 256) and byte_idx increments.
  - Transfer of byte 4 with reg_addr==LAST_REG → TRAILER.
  - Transfer of byte 4 otherwise → reg_addr+1, counter reloaded, back to SETTLE.
- TRAILER: out_valid=1, out_data=checksum (the 8-bit sum of every byte sent in this dump); moves to DONE on transfer.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- start is ignored in every state other than IDLE. It is never queued.
- reg_addr changes only on entry to SETTLE and on return to IDLE, so the core read port sees a stable address for at least SETTLE_CYCLES cycles.

## Timing
- Reset state: IDLE, busy=0, done=0, out_valid=0, out_data=0, reg_addr=0, checksum=0, byte_idx=0.
- rst mid-dump:
  - Aborts on the next edge with no further bytes and no done pulse.
  - out_valid may drop without a transfer only in this case.
- Stream rules:
  - While out_valid=1 and out_ready=0, out_data and out_valid hold unchanged.
  - out_valid never depends combinationally on out_ready.
  - Registered outputs allow at most one byte per cycle.
- Latency: with start sampled at edge E0, busy and reg_addr=FIRST_REG are visible after E0. The first out_valid appears after edge E_SETTLE_CYCLES.
- Full throughput (out_ready held at 1):
  - N = LAST_REG-FIRST_REG+1 registers.
  - Each register takes SETTLE_CYCLES+5 cycles.
  - The trailer takes 1 cycle.
  - done is visible after edge E_{N·(SETTLE_CYCLES+5)+1}.
- Wrap: reg_addr never wraps; LAST_REG=31 terminates without incrementing past 31.
- Checksum width is 8 bits; overflow is discarded.
- Bubble: there is no bubble between the trailer transfer and DONE, and none between DONE and IDLE.

## Test plan
- Single register (FIRST=LAST=1, SETTLE=1, x1=0x12345678, out_ready=1) → bytes 01 12 34 56 78, trailer 15. done rises 7 edges after start; busy falls the cycle after done.
- Full dump (defaults, x_i = i·0x01010101, out_ready=1) → 155 record bytes in ascending index order. First record is 01 01 01 01 01; last record is 1F 1F 1F 1F 1F. Trailer equals the bench-computed sum mod 256. done is visible 187 edges after start.
- Backpressure (random out_ready, ~30% high) → byte sequence identical to the ready=1 run. out_data never changes while valid=1 and ready=0. reg_addr holds during stalls.
- start pulses while busy (at cycles 3 and 20 of a dump) → ignored: byte count and trailer are unchanged, and there is exactly one done pulse.
- rst asserted for 1 cycle mid-SEND (byte 2 of x4) → the next cycle shows IDLE outputs (valid=0, busy=0, reg_addr=0). A new start then produces a complete correct dump starting at x1.
- SETTLE_CYCLES=3, x1 changed by the core during the settle window before the final settle cycle → the record carries the value present on the final settle cycle. reg_addr is stable for 3 cycles before each sample.
